mem_port_arbiter: RTL and testbench

- Shares one single-ported 64-word unified memory between the instruction-fetch port and the load/store data port of the pipelined core.
- Performs byte/halfword lane extraction with sign/zero extension on loads.
- Performs read-modify-write for sub-word stores.
- Flags misaligned accesses.
- Sits between the core's IF/MEM stages and the memory array; the array has combinational read when the read strobe is high and synchronous write.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_lane_unit.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IF/data memory port arbiter.
// Size codes, FSM states and the default fetch starvation limit.
package mem_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic {
    IDLE,
    RMW_WR
  } arb_state_t;

endpackage

// File: rtl/mem_lane_unit.sv
// Byte/halfword lane handling: load extract/extend,
// store merge and misalignment detection.
module mem_lane_unit
  import mem_arb_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] ld_data,
  output logic [31:0] st_word,
  output logic        misalign,
  output logic        sub_word
);

  logic       is_b;
  logic       is_h;
  logic       is_w;
  logic [7:0]  b_lane;
  logic [15:0] h_lane;

  assign is_b = (size == SZ_BYTE);
  assign is_h = (size == SZ_HALF);
  assign is_w = size[1];

  assign b_lane = rd_word[{off, 3'b000} +: 8];
  assign h_lane = rd_word[{off[1], 4'b0000} +: 16];

  assign misalign = (is_h & off[0]) | (is_w & (|off));
  assign sub_word = ~is_w;

  always_comb begin
    ld_data = rd_word;
    unique case (1'b1)
      is_b: ld_data = {{24{~uns & b_lane[7]}}, b_lane};
      is_h: ld_data = {{16{~uns & h_lane[15]}}, h_lane};
      is_w: ld_data = rd_word;
    endcase
  end

  always_comb begin
    st_word = old_word;
    unique case (1'b1)
      is_b: st_word[{off, 3'b000} +: 8] = wdata[7:0];
      is_h: st_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
      is_w: st_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one single-ported memory,
// with sub-word RMW stores and fetch starvation protection.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_misalign,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  arb_state_t  state_q;
  arb_state_t  state_d;
  logic [CW-1:0] starve_q;
  logic [31:0] merge_q;

  logic        if_gnt_c;
  logic        d_gnt_c;
  logic        rd_c;
  logic        wr_c;
  logic        latch_c;
  logic        fetch_pri;
  logic [31:0] ld_data;
  logic [31:0] st_word;
  logic        mis;
  logic        sub;
  logic        unused_if_lo;

  assign unused_if_lo = ^if_addr[1:0];

  mem_lane_unit u_lane (
    .rd_word  (mem_rdata),
    .old_word (merge_q),
    .wdata    (d_wdata),
    .off      (d_addr[1:0]),
    .size     (d_size),
    .uns      (d_unsigned),
    .ld_data  (ld_data),
    .st_word  (st_word),
    .misalign (mis),
    .sub_word (sub)
  );

  assign fetch_pri = if_req && (starve_q == CW'(STARVE_MAX));

  always_comb begin
    state_d   = state_q;
    if_gnt_c  = 1'b0;
    d_gnt_c   = 1'b0;
    rd_c      = 1'b0;
    wr_c      = 1'b0;
    latch_c   = 1'b0;
    mem_addr  = d_addr[ADDR_W-1:2];
    mem_wdata = d_wdata;
    unique case (state_q)
      IDLE: begin
        if (d_req && !fetch_pri) begin
          if (mis) begin
            d_gnt_c = 1'b1;
          end else if (!d_we) begin
            d_gnt_c = 1'b1;
            rd_c    = 1'b1;
          end else if (!sub) begin
            d_gnt_c = 1'b1;
            wr_c    = 1'b1;
          end else begin
            rd_c    = 1'b1;
            latch_c = 1'b1;
            state_d = RMW_WR;
          end
        end else if (if_req) begin
          if_gnt_c = 1'b1;
          rd_c     = 1'b1;
          mem_addr = if_addr[ADDR_W-1:2];
        end
      end
      RMW_WR: begin
        d_gnt_c   = 1'b1;
        wr_c      = 1'b1;
        mem_wdata = st_word;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_gnt    = if_gnt_c & rst_n;
  assign d_gnt     = d_gnt_c & rst_n;
  assign mem_read  = rd_c & rst_n;
  assign mem_write = wr_c & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counts every denied fetch cycle, including both RMW cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (if_gnt || !if_req) begin
      starve_q <= '0;
    end else if (starve_q != CW'(STARVE_MAX)) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      merge_q <= '0;
    end else if (latch_c) begin
      merge_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
    end else begin
      if_rvalid <= if_gnt;
      if (if_gnt) begin
        if_rdata <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_rvalid   <= 1'b0;
      d_misalign <= 1'b0;
      d_rdata    <= '0;
    end else begin
      d_rvalid   <= d_gnt;
      d_misalign <= d_gnt & mis;
      if (d_gnt) begin
        d_rdata <= (!d_we && !mis) ? ld_data : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter
// with a behavioural 64-word memory.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_misalign;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];
  int tests;
  int fails;

  mem_port_arbiter #(.ADDR_W(8), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_size     (d_size),
    .d_unsigned (d_unsigned),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_misalign (d_misalign),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? mem[mem_addr] : 32'd0;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic d_set(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [7:0] a,
                       input logic [31:0] wd);
    d_req      = 1'b1;
    d_we       = we;
    d_size     = sz;
    d_unsigned = uns;
    d_addr     = a;
    d_wdata    = wd;
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz,
                         input logic uns, input logic [7:0] a,
                         input logic [31:0] exp);
    @(negedge clk);
    d_set(1'b0, sz, uns, a, 32'd0);
    #1;
    chk({tag, "_gnt"}, 32'(d_gnt), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a[7:2]));
    @(posedge clk);
    #1;
    d_req = 1'b0;
    chk({tag, "_rvalid"}, 32'(d_rvalid), 32'd1);
    chk({tag, "_rdata"}, d_rdata, exp);
    chk({tag, "_mis"}, 32'(d_misalign), 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0] = 32'h0000_80FF;
    mem[1] = 32'h1122_3344;
    mem[2] = 32'd25;
    mem[3] = 32'hCAFE_0003;
    mem[4] = 32'h1234_5678;
    mem[5] = 32'h5566_7788;
    rst_n = 1'b0;
    if_req = 1'b0;
    if_addr = 8'd0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_size = SZ_WORD;
    d_unsigned = 1'b0;
    d_addr = 8'd0;
    d_wdata = 32'd0;

    // reset state with a request pending
    if_req = 1'b1;
    d_req  = 1'b1;
    #12;
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    if_req = 1'b0;
    d_req  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: word load
    do_load("lw8", SZ_WORD, 1'b0, 8'd8, 32'd25);
    @(posedge clk);
    #1;
    chk("lw8_pulse", 32'(d_rvalid), 32'd0);

    // 2: byte/half extraction
    do_load("lb1", SZ_BYTE, 1'b0, 8'd1, 32'hFFFF_FF80);
    do_load("lbu1", SZ_BYTE, 1'b1, 8'd1, 32'h0000_0080);
    do_load("lh0", SZ_HALF, 1'b0, 8'd0, 32'hFFFF_80FF);

    // 3: sub-word store with fetch pending
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 8'd16;
    d_set(1'b1, SZ_BYTE, 1'b0, 8'd6, 32'h0000_00AB);
    #1;
    chk("sb_c1_dgnt", 32'(d_gnt), 32'd0);
    chk("sb_c1_ifgnt", 32'(if_gnt), 32'd0);
    chk("sb_c1_rd", 32'(mem_read), 32'd1);
    @(posedge clk);
    #1;
    chk("sb_c2_dgnt", 32'(d_gnt), 32'd1);
    chk("sb_c2_ifgnt", 32'(if_gnt), 32'd0);
    chk("sb_c2_wr", 32'(mem_write), 32'd1);
    chk("sb_c2_rd", 32'(mem_read), 32'd0);
    chk("sb_c2_wdata", mem_wdata, 32'h11AB_3344);
    @(posedge clk);
    #1;
    d_req  = 1'b0;
    if_req = 1'b0;
    chk("sb_ack", 32'(d_rvalid), 32'd1);
    chk("sb_mem", mem[1], 32'h11AB_3344);
    chk("sb_no_ifrv", 32'(if_rvalid), 32'd0);
    @(negedge clk);
    @(negedge clk);

    // 4: starvation pattern
    if_req  = 1'b1;
    if_addr = 8'd16;
    d_set(1'b0, SZ_WORD, 1'b0, 8'd12, 32'd0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("stv%0d_dgnt", i), 32'(d_gnt),
          32'((i % 5) != 4));
      chk($sformatf("stv%0d_ifgnt", i), 32'(if_gnt),
          32'((i % 5) == 4));
      if (i > 0) begin
        chk($sformatf("stv%0d_drv", i), 32'(d_rvalid),
            32'(((i - 1) % 5) != 4));
        chk($sformatf("stv%0d_ifrv", i), 32'(if_rvalid),
            32'(((i - 1) % 5) == 4));
        if (((i - 1) % 5) == 4)
          chk($sformatf("stv%0d_ifdat", i), if_rdata, 32'h1234_5678);
        else
          chk($sformatf("stv%0d_ddat", i), d_rdata, 32'hCAFE_0003);
      end
      @(negedge clk);
    end
    d_req  = 1'b0;
    if_req = 1'b0;
    #1;
    chk("stv_last_ifrv", 32'(if_rvalid), 32'd1);
    chk("stv_last_drv", 32'(d_rvalid), 32'd0);
    @(negedge clk);

    // 5: misaligned word load
    @(negedge clk);
    d_set(1'b0, SZ_WORD, 1'b0, 8'd6, 32'd0);
    #1;
    chk("mlw_gnt", 32'(d_gnt), 32'd1);
    chk("mlw_strobe", 32'({mem_read, mem_write}), 32'd0);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    chk("mlw_rv", 32'(d_rvalid), 32'd1);
    chk("mlw_mis", 32'(d_misalign), 32'd1);
    chk("mlw_rdata", d_rdata, 32'd0);

    // 5b: misaligned half store
    @(negedge clk);
    d_set(1'b1, SZ_HALF, 1'b0, 8'd3, 32'h0000_BEEF);
    #1;
    chk("msh_gnt", 32'(d_gnt), 32'd1);
    chk("msh_strobe", 32'({mem_read, mem_write}), 32'd0);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    chk("msh_rv", 32'(d_rvalid), 32'd1);
    chk("msh_mis", 32'(d_misalign), 32'd1);
    chk("msh_rdata", d_rdata, 32'd0);
    chk("msh_mem", mem[0], 32'h0000_80FF);

    // 6: reset during RMW write cycle
    @(negedge clk);
    d_set(1'b1, SZ_BYTE, 1'b0, 8'd20, 32'h0000_0099);
    @(posedge clk);
    #1;
    chk("rr_wr_pre", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rr_wr_drop", 32'(mem_write), 32'd0);
    chk("rr_gnt_drop", 32'(d_gnt), 32'd0);
    @(posedge clk);
    #1;
    chk("rr_mem", mem[5], 32'h5566_7788);
    chk("rr_no_ack", 32'(d_rvalid), 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 8'd16;
    #1;
    chk("rr_if_gnt", 32'(if_gnt), 32'd1);
    chk("rr_if_rd", 32'(mem_read), 32'd1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    chk("rr_if_rv", 32'(if_rvalid), 32'd1);
    chk("rr_if_data", if_rdata, 32'h1234_5678);
    chk("rr_d_rv", 32'(d_rvalid), 32'd0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
